// File: rtl/front_end_pkg.sv
// Shared front-end types: fetch FSM states, redirect source codes and default
// address parameters used by fetch_pc_sequencer and its redirect mux.
package front_end_pkg;

  localparam int unsigned XLEN_DEF     = 64;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    BOOT        = 2'd0,
    RUN         = 2'd1,
    CREDIT_WAIT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    BACKEND  = 2'd1,
    RESOLVE  = 2'd2,
    PRESOLVE = 2'd3
  } redirect_src_e;

endpackage

// File: rtl/fetch_pc_sequencer_chk.sv
// Protocol checker for fetch_pc_sequencer: flags icache responses that arrive
// while no request is in flight.
module fetch_pc_sequencer_chk #(
  parameter int unsigned CW = 2
) (
  input logic          clock,
  input logic          reset,
  input logic          data_valid_i,
  input logic [CW-1:0] outstanding_i
);

  a_no_orphan_resp: assert property (@(posedge clock) disable iff (!reset)
    data_valid_i |-> (outstanding_i != '0))
    else $error("icache response with no request outstanding");

endmodule

// File: rtl/fetch_redirect_mux.sv
// Fixed-priority redirect select: backend redirect, then mispredicted resolve,
// then taken predecode branch. Purely combinational.
module fetch_redirect_mux
  import front_end_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            backend_valid_i,
  input  logic [XLEN-1:0] backend_target_i,
  input  logic            resolve_valid_i,
  input  logic            resolve_mispred_i,
  input  logic [XLEN-1:0] resolve_target_i,
  input  logic            presolve_valid_i,
  input  logic            presolve_taken_i,
  input  logic [XLEN-1:0] presolve_target_i,
  output logic            redirect_valid_o,
  output redirect_src_e   redirect_src_o,
  output logic [XLEN-1:0] redirect_target_o
);

  // Priority encode the three redirect sources
  always_comb begin
    redirect_valid_o  = 1'b0;
    redirect_src_o    = NONE;
    redirect_target_o = '0;
    if (backend_valid_i) begin
      redirect_valid_o  = 1'b1;
      redirect_src_o    = BACKEND;
      redirect_target_o = backend_target_i;
    end else if (resolve_valid_i && resolve_mispred_i) begin
      redirect_valid_o  = 1'b1;
      redirect_src_o    = RESOLVE;
      redirect_target_o = resolve_target_i;
    end else if (presolve_valid_i && presolve_taken_i) begin
      redirect_valid_o  = 1'b1;
      redirect_src_o    = PRESOLVE;
      redirect_target_o = presolve_target_i;
    end else begin
      redirect_valid_o  = 1'b0;
      redirect_src_o    = NONE;
      redirect_target_o = '0;
    end
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Stage-1 fetch PC owner: issues fetch addresses to the icache, tags responses with
// their PC and marks pre-redirect responses stale. Optional macro: FETCH_PERF_CNT_EN.
module fetch_pc_sequencer
  import front_end_pkg::*;
#(
  parameter int unsigned     XLEN            = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF),
  parameter int unsigned     FETCH_BYTES     = 8,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  localparam int unsigned    CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_i_pc_redirect_valid,
  input  logic [XLEN-1:0] io_i_pc_redirect_target,
  input  logic            io_i_branch_resolve_pack_valid,
  input  logic            io_i_branch_resolve_pack_mispred,
  input  logic [XLEN-1:0] io_i_branch_resolve_pack_target,
  input  logic            io_i_branch_presolve_pack_valid,
  input  logic            io_i_branch_presolve_pack_taken,
  input  logic [XLEN-1:0] io_i_branch_presolve_pack_target,
  input  logic            io_i_stage1_stall,
  output logic            io_o_icache_addr_valid,
  output logic [XLEN-1:0] io_o_icache_addr,
  input  logic            io_i_icache_addr_ready,
  input  logic            io_i_icache_data_valid,
  output logic [XLEN-1:0] io_o_resp_pc,
  output logic            io_o_resp_kill,
  output logic [CW-1:0]   io_o_outstanding
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     io_o_perf_redirects,
  output logic [31:0]     io_o_perf_kills
`endif
);

  localparam int unsigned     PW         = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [XLEN-1:0] FETCH_STEP = XLEN'(FETCH_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(FETCH_STEP - XLEN'(1));
  localparam logic [CW-1:0]   MAX_CNT    = CW'(MAX_OUTSTANDING);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   kill_cnt_q, kill_cnt_d;
  logic [XLEN-1:0] tag_mem_q [MAX_OUTSTANDING];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;

  logic            redir_valid_s;
  redirect_src_e   redir_src_s;
  logic [XLEN-1:0] redir_target_s;
  logic            redirect_s, accept_s, resp_s, kill_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
    else return p + PW'(1);
  endfunction

  fetch_redirect_mux #(.XLEN(XLEN)) u_redirect_mux (
    .backend_valid_i   (io_i_pc_redirect_valid),
    .backend_target_i  (io_i_pc_redirect_target),
    .resolve_valid_i   (io_i_branch_resolve_pack_valid),
    .resolve_mispred_i (io_i_branch_resolve_pack_mispred),
    .resolve_target_i  (io_i_branch_resolve_pack_target),
    .presolve_valid_i  (io_i_branch_presolve_pack_valid),
    .presolve_taken_i  (io_i_branch_presolve_pack_taken),
    .presolve_target_i (io_i_branch_presolve_pack_target),
    .redirect_valid_o  (redir_valid_s),
    .redirect_src_o    (redir_src_s),
    .redirect_target_o (redir_target_s)
  );

  assign redirect_s = redir_valid_s & (redir_src_s != NONE);
  assign accept_s   = io_o_icache_addr_valid & io_i_icache_addr_ready;
  // Responses with nothing in flight (e.g. left over from before a reset) are dropped.
  assign resp_s     = io_i_icache_data_valid & (outstanding_q != '0);
  assign kill_s     = resp_s & (kill_cnt_q != '0);

  // Next-state for in-flight count, kill budget and fetch PC
  always_comb begin
    outstanding_d = outstanding_q;
    kill_cnt_d    = kill_cnt_q;
    pc_d          = pc_q;
    case ({accept_s, resp_s})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (redirect_s) begin
      kill_cnt_d = outstanding_d;
      pc_d       = redir_target_s;
    end else begin
      if (kill_s) kill_cnt_d = kill_cnt_q - CW'(1);
      else kill_cnt_d = kill_cnt_q;
      if (accept_s) pc_d = (pc_q & ALIGN_MASK) + FETCH_STEP;
      else pc_d = pc_q;
    end
  end

  // Fetch FSM: credit wait holds issue until a response frees a slot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
    end else begin
      case (state_q)
        BOOT:        state_q <= RUN;
        RUN:         state_q <= (outstanding_d == MAX_CNT) ? CREDIT_WAIT : RUN;
        CREDIT_WAIT: state_q <= resp_s ? RUN : CREDIT_WAIT;
        default:     state_q <= BOOT;
      endcase
    end
  end

  // PC, counters and the inline tag FIFO
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) tag_mem_q[i] <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
      if (resp_s) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (accept_s) begin
        tag_mem_q[wr_ptr_q] <= pc_q;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
    end
  end

  assign io_o_icache_addr_valid = (state_q == RUN) & ~io_i_stage1_stall;
  assign io_o_icache_addr       = pc_q;
  assign io_o_resp_pc           = tag_mem_q[rd_ptr_q];
  assign io_o_resp_kill         = kill_s;
  assign io_o_outstanding       = outstanding_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_q, perf_kills_q;

  // Saturating event counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_redirects_q <= 32'd0;
      perf_kills_q     <= 32'd0;
    end else begin
      if (redirect_s && (perf_redirects_q != 32'hFFFF_FFFF)) perf_redirects_q <= perf_redirects_q + 32'd1;
      if (kill_s && (perf_kills_q != 32'hFFFF_FFFF)) perf_kills_q <= perf_kills_q + 32'd1;
    end
  end

  assign io_o_perf_redirects = perf_redirects_q;
  assign io_o_perf_kills     = perf_kills_q;
`endif

endmodule
